// File: rtl/calc_pkg.sv
// Constants and state encoding shared by the calculator sequencer, the keypad
// decoder and the ALU.
package calc_pkg;

  typedef enum logic [2:0] {
    S_A, S_OP, S_B, S_EXEC, S_WAIT, S_RES, S_ERR
  } state_e;

  localparam logic [1:0] OP_ADD = 2'd1;
  localparam logic [1:0] OP_SUB = 2'd2;
  localparam int         MAX_VAL = 9999;

  function automatic logic op_is_valid(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/calc_controller_key_event.sv
// Rising-edge detector on the decoder's key-active level: one event per press,
// with the key fields taken from the same cycle as the edge.
module calc_key_event (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_press,
  input  logic       is_num,
  input  logic       is_op,
  input  logic       is_eq,
  input  logic [3:0] num_val,
  input  logic [1:0] op_val,
  output logic       ev_valid,
  output logic       ev_num,
  output logic       ev_op,
  output logic       ev_eq,
  output logic [3:0] ev_digit,
  output logic [1:0] ev_opcode
);

  logic btn_d, btn_q;

  always_comb begin
    btn_d     = btn_press;
    ev_valid  = btn_press & ~btn_q;
    ev_num    = is_num;
    ev_op     = is_op;
    ev_eq     = is_eq;
    ev_digit  = num_val;
    ev_opcode = op_val;
  end

  always_ff @(posedge clk) begin
    if (rst) btn_q <= 1'b0;
    else     btn_q <= btn_d;
  end

endmodule

// File: rtl/calc_controller.sv
// Calculator sequencer: key events -> two decimal operands -> one ALU add/sub
// through a start/done handshake -> registered display value.
module calc_controller
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS  = 4,
  parameter int W           = 14,
  parameter int ALU_TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           btn_press,
  input  logic           is_num,
  input  logic           is_op,
  input  logic           is_eq,
  input  logic [3:0]     num_val,
  input  logic [1:0]     op_val,
  output logic           alu_start,
  output logic [1:0]     alu_op,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  input  logic           alu_done,
  input  logic [W+1:0]   alu_result,
  output logic [W-1:0]   disp_val,
  output logic           disp_neg,
  output logic           disp_err,
  output logic           busy
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int TW = $clog2(ALU_TIMEOUT + 1);
  localparam logic [CW-1:0]       CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]       CNT_MAX   = CW'(MAX_DIGITS);
  localparam logic [TW-1:0]       TIMER_END = TW'(ALU_TIMEOUT - 1);
  localparam logic signed [W+1:0] RES_MAX   = (W+2)'(MAX_VAL);
  localparam logic signed [W+1:0] RES_MIN   = -RES_MAX;

  logic       ev_valid, ev_num, ev_op, ev_eq;
  logic [3:0] ev_digit;
  logic [1:0] ev_opcode;

  calc_key_event u_key_event (
    .clk       (clk),
    .rst       (rst),
    .btn_press (btn_press),
    .is_num    (is_num),
    .is_op     (is_op),
    .is_eq     (is_eq),
    .num_val   (num_val),
    .op_val    (op_val),
    .ev_valid  (ev_valid),
    .ev_num    (ev_num),
    .ev_op     (ev_op),
    .ev_eq     (ev_eq),
    .ev_digit  (ev_digit),
    .ev_opcode (ev_opcode)
  );

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [CW-1:0]   cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [1:0]      op_q, op_d;
  logic [W+1:0]    result_q, result_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            alu_start_q, alu_start_d;
  logic [W-1:0]    disp_val_q, disp_val_d;
  logic            disp_neg_q, disp_neg_d;
  logic            disp_err_q, disp_err_d;
  logic            busy_q, busy_d;

  logic key_num, key_op, key_eq, out_of_range;
  logic [W-1:0] digit_w;

  // a*10 + d as two shifts and an add; the digit counter keeps it in range.
  function automatic logic [W-1:0] shift_add(input logic [W-1:0] v, input logic [3:0] d);
    return (v << 3) + (v << 1) + W'(d);
  endfunction

  always_comb begin
    key_num      = ev_valid & ev_num;
    key_op       = ev_valid & ev_op & op_is_valid(ev_opcode);
    key_eq       = ev_valid & ev_eq;
    digit_w      = W'(ev_digit);
    out_of_range = ($signed(alu_result) > RES_MAX) || ($signed(alu_result) < RES_MIN);
  end

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block can infer a latch.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_a_d  = cnt_a_q;
    cnt_b_d  = cnt_b_q;
    op_d     = op_q;
    result_d = result_q;
    timer_d  = timer_q;

    case (state_q)
      S_A: begin
        if (key_num) begin
          if (cnt_a_q < CNT_MAX) begin
            a_d     = shift_add(a_q, ev_digit);
            cnt_a_d = cnt_a_q + CNT_ONE;
          end
        end else if (key_op) begin
          op_d    = ev_opcode;
          state_d = S_OP;
        end
      end
      S_OP: begin
        if (key_num) begin
          b_d     = digit_w;
          cnt_b_d = CNT_ONE;
          state_d = S_B;
        end else if (key_op) begin
          op_d = ev_opcode;
        end
      end
      S_B: begin
        if (key_num) begin
          if (cnt_b_q < CNT_MAX) begin
            b_d     = shift_add(b_q, ev_digit);
            cnt_b_d = cnt_b_q + CNT_ONE;
          end
        end else if (key_eq) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (alu_done) begin
          result_d = alu_result;
          state_d  = out_of_range ? S_ERR : S_RES;
        end else if (timer_q == TIMER_END) begin
          state_d = S_ERR;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RES: begin
        if (key_num) begin
          a_d     = digit_w;
          b_d     = '0;
          cnt_a_d = CNT_ONE;
          state_d = S_A;
        end else if (key_op && !result_q[W+1]) begin
          // Chained operation: the result becomes operand A and is closed to digits.
          a_d     = W'(result_q);
          cnt_a_d = CNT_MAX;
          op_d    = ev_opcode;
          state_d = S_OP;
        end
      end
      S_ERR: begin
        if (key_num) begin
          a_d     = digit_w;
          cnt_a_d = CNT_ONE;
          state_d = S_A;
        end
      end
      default: state_d = S_A;
    endcase

    // Outputs are computed from next-state values so the registered copy is current.
    alu_start_d = (state_d == S_EXEC);
    busy_d      = (state_d == S_EXEC) || (state_d == S_WAIT);
    disp_neg_d  = 1'b0;
    disp_err_d  = 1'b0;
    case (state_d)
      S_A, S_OP: disp_val_d = a_d;
      S_RES: begin
        disp_val_d = result_d[W+1] ? W'(-result_d) : W'(result_d);
        disp_neg_d = result_d[W+1];
      end
      S_ERR: begin
        disp_val_d = '0;
        disp_err_d = 1'b1;
      end
      default: disp_val_d = b_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_A;
      a_q         <= '0;
      b_q         <= '0;
      cnt_a_q     <= '0;
      cnt_b_q     <= '0;
      op_q        <= '0;
      result_q    <= '0;
      timer_q     <= '0;
      alu_start_q <= 1'b0;
      disp_val_q  <= '0;
      disp_neg_q  <= 1'b0;
      disp_err_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge _d values.
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_a_q     <= cnt_a_d;
      cnt_b_q     <= cnt_b_d;
      op_q        <= op_d;
      result_q    <= result_d;
      timer_q     <= timer_d;
      alu_start_q <= alu_start_d;
      disp_val_q  <= disp_val_d;
      disp_neg_q  <= disp_neg_d;
      disp_err_q  <= disp_err_d;
      busy_q      <= busy_d;
    end
  end

  assign alu_start = alu_start_q;
  assign alu_op    = op_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign disp_val  = disp_val_q;
  assign disp_neg  = disp_neg_q;
  assign disp_err  = disp_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_calc_controller.sv
// Scoreboard bench for calc_controller: stimulus pushes expected launches and
// displays computed arithmetically; a monitor pops them as the DUT presents them.
module tb_calc_controller;
  import calc_pkg::*;

  localparam int MAX_DIGITS  = 4;
  localparam int W           = 14;
  localparam int ALU_TIMEOUT = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           btn_press, is_num, is_op, is_eq;
  logic [3:0]     num_val;
  logic [1:0]     op_val;
  logic           alu_start;
  logic [1:0]     alu_op;
  logic [W-1:0]   alu_a, alu_b;
  logic           alu_done;
  logic [W+1:0]   alu_result;
  logic [W-1:0]   disp_val;
  logic           disp_neg, disp_err, busy;

  calc_controller #(.MAX_DIGITS(MAX_DIGITS), .W(W), .ALU_TIMEOUT(ALU_TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_press  (btn_press),
    .is_num     (is_num),
    .is_op      (is_op),
    .is_eq      (is_eq),
    .num_val    (num_val),
    .op_val     (op_val),
    .alu_start  (alu_start),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .disp_val   (disp_val),
    .disp_neg   (disp_neg),
    .disp_err   (disp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct { int a; int b; int op; } launch_t;
  typedef struct { int val; int neg; int err; } res_t;

  launch_t launch_q[$];
  res_t    res_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int alu_mode    = 0;   // 0: answers after random latency, 1: never answers
  int inject_req  = 0;
  int last_res    = 0;
  bit last_ok     = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Value the operand should hold after n digits of v: only the first MAX_DIGITS count.
  function automatic int entered(input int v, input int n);
    return (n > MAX_DIGITS) ? v / pow10(n - MAX_DIGITS) : v;
  endfunction

  // ALU model: samples a launch, answers a+b or a-b some cycles later.
  initial begin
    int pend, pend_res, seen;
    pend = 0; pend_res = 0; seen = 0;
    alu_done = 1'b0; alu_result = '0;
    forever begin
      @(posedge clk); #1;
      alu_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          alu_done   = 1'b1;
          alu_result = (W+2)'(pend_res);
        end
      end
      if (inject_req != seen) begin
        seen       = inject_req;
        alu_done   = 1'b1;
        alu_result = (W+2)'(5);
      end
      if (alu_start && alu_mode == 0) begin
        pend     = $urandom_range(1, 5);
        pend_res = (alu_op == OP_SUB) ? int'(alu_a) - int'(alu_b) : int'(alu_a) + int'(alu_b);
      end
    end
  end

  // Monitor: pops expectations when a launch appears or an operation finishes.
  initial begin
    bit prev_busy, prev_rst, prev_start;
    launch_t l;
    res_t    r;
    prev_busy = 0; prev_rst = 1; prev_start = 0;
    forever begin
      @(negedge clk);
      if (prev_start) check("alu_start_pulse", int'(alu_start), 0);
      if (alu_start && !prev_start) begin
        if (launch_q.size() == 0) check("launch_queue", launch_q.size(), 1);
        else begin
          l = launch_q.pop_front();
          check("alu_a", int'(alu_a), l.a);
          check("alu_b", int'(alu_b), l.b);
          check("alu_op", int'(alu_op), l.op);
        end
      end
      if (prev_busy && !busy && !prev_rst && !rst) begin
        if (res_q.size() == 0) check("result_queue", res_q.size(), 1);
        else begin
          r = res_q.pop_front();
          check("disp_val", int'(disp_val), r.val);
          check("disp_neg", int'(disp_neg), r.neg);
          check("disp_err", int'(disp_err), r.err);
        end
      end
      prev_busy  = busy;
      prev_rst   = rst;
      prev_start = alu_start;
    end
  end

  task automatic press(input int kind, input int val, input int hold);
    @(posedge clk); #1;
    btn_press = 1'b1;
    is_num    = (kind == 0);
    is_op     = (kind == 1);
    is_eq     = (kind == 2);
    num_val   = 4'(val);
    op_val    = 2'(val);
    repeat (hold) @(posedge clk);
    #1;
    btn_press = 1'b0; is_num = 1'b0; is_op = 1'b0; is_eq = 1'b0;
  endtask

  task automatic type_num(input int v, input int n);
    for (int i = n - 1; i >= 0; i--) press(0, (v / pow10(i)) % 10, $urandom_range(1, 3));
  endtask

  task automatic wait_settle();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("settle_busy", int'(busy), 0);
  endtask

  task automatic wait_for_wait_state();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (dut.state_q == S_WAIT) break;
    end
    check("reach_wait", int'(dut.state_q), int'(S_WAIT));
  endtask

  // One calculation; an == 0 chains from the previous non-negative result.
  task automatic run_calc(input int av, input int an, input int op,
                          input int bv, input int bn, input bit noise);
    int a_exp, b_exp, r;
    launch_t l;
    res_t e;
    if (noise) press(2, 0, 1);
    if (an == 0) a_exp = last_res;
    else begin
      type_num(av, an);
      a_exp = entered(av, an);
    end
    if (noise) begin
      press(1, 3, 1);
      press(1, (op == 1) ? 2 : 1, 1);
      press(1, 0, 1);
    end
    press(1, op, 1);
    type_num(bv, bn);
    b_exp = entered(bv, bn);
    if (noise) press(1, 1, 1);
    l = '{a_exp, b_exp, op};
    launch_q.push_back(l);
    r = (op == 1) ? a_exp + b_exp : a_exp - b_exp;
    if (r > MAX_VAL || r < -MAX_VAL) begin
      e = '{0, 0, 1};
      last_ok = 1'b0;
    end else begin
      e = '{(r < 0) ? -r : r, (r < 0) ? 1 : 0, 0};
      last_ok  = (r >= 0);
      last_res = r;
    end
    res_q.push_back(e);
    press(2, 0, $urandom_range(1, 3));
    wait_settle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    launch_t l;
    res_t    e;
    int      n, an, bn, av, bv, op;
    bit      chain, noise;

    rst = 1'b1; btn_press = 1'b0; is_num = 1'b0; is_op = 1'b0; is_eq = 1'b0;
    num_val = '0; op_val = '0;

    @(posedge clk);
    @(negedge clk);
    check("rst_alu_start", int'(alu_start), 0);
    check("rst_alu_op", int'(alu_op), 0);
    check("rst_alu_a", int'(alu_a), 0);
    check("rst_alu_b", int'(alu_b), 0);
    check("rst_disp_val", int'(disp_val), 0);
    check("rst_disp_neg", int'(disp_neg), 0);
    check("rst_disp_err", int'(disp_err), 0);
    check("rst_busy", int'(busy), 0);
    @(posedge clk); #1 rst = 1'b0;

    // 12 + 34, then chained + 4
    run_calc(12, 2, 1, 34, 2, 1'b0);
    check("sum_46", int'(disp_val), 46);
    run_calc(0, 0, 1, 4, 1, 1'b0);
    check("chain_50", int'(disp_val), 50);

    // 5 - 8 shows a negative result
    run_calc(5, 1, 2, 8, 1, 1'b0);
    check("neg_state", int'(dut.state_q), int'(S_RES));
    check("neg_val", int'(disp_val), 3);
    check("neg_flag", int'(disp_neg), 1);

    // fifth digit dropped, 9999 + 9999 overflows the display
    run_calc(99999, 5, 1, 9999, 4, 1'b0);
    check("ovf_err", int'(disp_err), 1);
    check("ovf_val", int'(disp_val), 0);

    // held key yields one digit
    press(0, 2, 20);
    @(negedge clk);
    check("held_digit", int'(disp_val), 2);
    press(0, 5, 1);
    @(negedge clk);
    check("second_digit", int'(disp_val), 25);

    // ALU never answers: error exactly ALU_TIMEOUT cycles into S_WAIT
    alu_mode = 1;
    l = '{25, 1, 1}; launch_q.push_back(l);
    e = '{0, 0, 1};  res_q.push_back(e);
    press(1, 1, 1);
    press(0, 1, 1);
    press(2, 0, 1);
    wait_for_wait_state();
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (dut.state_q != S_WAIT) break;
    end
    check("timeout_cycles", n, ALU_TIMEOUT);
    check("timeout_state", int'(dut.state_q), int'(S_ERR));
    press(0, 7, 1);
    @(negedge clk);
    check("after_err_val", int'(disp_val), 7);
    check("after_err_flag", int'(disp_err), 0);
    check("after_err_state", int'(dut.state_q), int'(S_A));

    // reset in the middle of the handshake, then a stale alu_done
    l = '{7, 4, 2}; launch_q.push_back(l);
    press(1, 2, 1);
    press(0, 4, 1);
    press(2, 0, 1);
    wait_for_wait_state();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", int'(busy), 0);
    check("midrst_alu_op", int'(alu_op), 0);
    check("midrst_alu_a", int'(alu_a), 0);
    check("midrst_alu_b", int'(alu_b), 0);
    check("midrst_disp_val", int'(disp_val), 0);
    inject_req++;
    repeat (3) @(negedge clk);
    check("stale_done_state", int'(dut.state_q), int'(S_A));
    check("stale_done_val", int'(disp_val), 0);
    check("stale_done_neg", int'(disp_neg), 0);
    check("stale_done_err", int'(disp_err), 0);
    alu_mode = 0;
    last_ok  = 1'b0;

    // randomized calculations
    for (int t = 0; t < 40; t++) begin
      an    = $urandom_range(1, 6);
      bn    = $urandom_range(1, 6);
      av    = $urandom_range(0, pow10(an) - 1);
      bv    = $urandom_range(0, pow10(bn) - 1);
      op    = $urandom_range(1, 2);
      noise = ($urandom_range(0, 1) == 1);
      chain = last_ok && ($urandom_range(0, 3) == 0);
      run_calc(av, chain ? 0 : an, op, bv, bn, noise);
    end

    repeat (3) @(negedge clk);
    check("launch_q_drained", launch_q.size(), 0);
    check("res_q_drained", res_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
